pico_ctrl: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the picoMIPS datapath. It sits directly upstream of the ALU and drives it. Each cycle-stepped instruction does the following:
- reads the synchronous program ROM;
- decodes the opcode into an ALU function code, register addresses and an immediate select;
- latches the ALU flags;
- resolves branches;
- handles the external-input handshake;
- issues a single register-file write strobe.

---
 rtl/pico_pkg.sv | 62 ++++++
 rtl/pico_if.sv | 37 +++
 rtl/pico_decode.sv | 32 +++
 rtl/pico_ctrl.sv | 153 +++++++++++++++
 tb/tb_pico_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pico_pkg.sv
// pico_pkg: shared definitions for the picoMIPS controller.
// Holds the ALU function codes, opcode and state enums, instruction
// field positions, the register address width and the decoded control bundle.
package pico_pkg;

  localparam int unsigned REG_AW = 2;
  localparam int unsigned ALU_FW = 3;

  // Instruction field bit positions
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS_MSB  = 9;
  localparam int unsigned RS_LSB  = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  // Bit index of Z in the ALU flag vector {N, Z, C, V}
  localparam int unsigned FLAG_Z = 2;

  // ALU function codes shared with the ALU
  localparam logic [ALU_FW-1:0] RNOP = 3'd0;
  localparam logic [ALU_FW-1:0] RADD = 3'd1;
  localparam logic [ALU_FW-1:0] RSUB = 3'd2;
  localparam logic [ALU_FW-1:0] RMUL = 3'd3;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_ADDI = 4'h2,
    OP_SUB  = 4'h3,
    OP_SUBI = 4'h4,
    OP_MUL  = 4'h5,
    OP_MULI = 4'h6,
    OP_BEQ  = 4'h7,
    OP_BNE  = 4'h8,
    OP_J    = 4'h9,
    OP_IN   = 4'hA,
    OP_HALT = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT_IN,
    S_WB,
    S_HALT
  } state_e;

  typedef struct packed {
    logic [ALU_FW-1:0] alu_func;
    logic              imm_sel;
    logic              is_alu;
    logic              is_branch;
    logic              is_in;
    logic              is_halt;
    logic              illegal;
  } ctrl_t;

endpackage

// File: rtl/pico_if.sv
// pico_if: controller <-> datapath/ROM/input-port signal bundle.
// master: controller side (drives pc, ALU controls, write strobe, in_ready).
// slave : environment side (drives ROM data, ALU flags, input word).
interface pico_if #(
  parameter int unsigned n  = 8,
  parameter int unsigned PW = 8,
  parameter int unsigned IW = 16
);
  logic [PW-1:0] pc_out;
  logic [IW-1:0] instr;
  logic [2:0]    alu_func;
  logic [3:0]    flags;
  logic [1:0]    ra1;
  logic [1:0]    ra2;
  logic [1:0]    wa;
  logic [n-1:0]  imm;
  logic          imm_sel;
  logic          reg_we;
  logic          wd_sel;
  logic [n-1:0]  ext_data;
  logic          in_valid;
  logic [n-1:0]  in_data;
  logic          in_ready;
  logic          halted;

  modport master (
    output pc_out, alu_func, ra1, ra2, wa, imm, imm_sel,
           reg_we, wd_sel, ext_data, in_ready, halted,
    input  instr, flags, in_valid, in_data
  );

  modport slave (
    input  pc_out, alu_func, ra1, ra2, wa, imm, imm_sel,
           reg_we, wd_sel, ext_data, in_ready, halted,
    output instr, flags, in_valid, in_data
  );
endinterface

// File: rtl/pico_decode.sv
// pico_decode: combinational opcode decoder.
// Ports: opcode (in, 4) -> ctrl (out, ctrl_t: alu_func, imm_sel, class bits).
// Macro PICO_MUL_EN: when defined, MUL/MULI decode to RMUL ALU ops;
// otherwise opcodes 5 and 6 are flagged illegal.
module pico_decode
  import pico_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.alu_func = RNOP;
    case (opcode)
      OP_NOP: ;
      OP_ADD:  begin ctrl.alu_func = RADD; ctrl.is_alu = 1'b1; end
      OP_ADDI: begin ctrl.alu_func = RADD; ctrl.is_alu = 1'b1; ctrl.imm_sel = 1'b1; end
      OP_SUB:  begin ctrl.alu_func = RSUB; ctrl.is_alu = 1'b1; end
      OP_SUBI: begin ctrl.alu_func = RSUB; ctrl.is_alu = 1'b1; ctrl.imm_sel = 1'b1; end
`ifdef PICO_MUL_EN
      OP_MUL:  begin ctrl.alu_func = RMUL; ctrl.is_alu = 1'b1; end
      OP_MULI: begin ctrl.alu_func = RMUL; ctrl.is_alu = 1'b1; ctrl.imm_sel = 1'b1; end
`endif
      OP_BEQ, OP_BNE, OP_J: ctrl.is_branch = 1'b1;
      OP_IN:   ctrl.is_in   = 1'b1;
      OP_HALT: ctrl.is_halt = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pico_ctrl.sv
// pico_ctrl: multi-cycle fetch/decode/execute sequencer for picoMIPS.
// Ports: clk, reset (async, active-high), bus (pico_if.master): ROM address/
// data, ALU function/operand selects, flags, register write strobe, input
// handshake and halted status. All bus outputs are registered.
// Macro PICO_MUL_EN (see pico_decode) enables MUL/MULI.
module pico_ctrl
  import pico_pkg::*;
#(
  parameter int unsigned n  = 8,
  parameter int unsigned PW = 8,
  parameter int unsigned IW = 16
) (
  input  logic      clk,
  input  logic      reset,
  pico_if.master    bus
);

  state_e              state_q, state_d;
  logic [PW-1:0]       pc_q, pc_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic [3:0]          flag_q, flag_d;
  logic [n-1:0]        ext_q, ext_d;
  logic [n-1:0]        imm_q, imm_d;
  logic [ALU_FW-1:0]   alu_func_q, alu_func_d;
  logic [REG_AW-1:0]   ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d;
  logic                imm_sel_q, imm_sel_d;
  logic                reg_we_q, reg_we_d;
  logic                wd_sel_q, wd_sel_d;
  logic                in_ready_q, in_ready_d;
  logic                halted_q, halted_d;
  logic                taken;
  ctrl_t               dec;

  // IR loads in DECODE; decoding the next IR lets the held controls be registered
  assign ir_d = (state_q == S_DECODE) ? bus.instr : ir_q;

  pico_decode u_decode (
    .opcode (ir_d[OP_MSB:OP_LSB]),
    .ctrl   (dec)
  );

  // Next state, architectural state and registered outputs
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    ext_d   = ext_q;
    taken   = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (dec.illegal) begin
          pc_d    = pc_q + PW'(1);
          state_d = S_FETCH;
        end else if (dec.is_alu) begin
          flag_d  = bus.flags;
          state_d = S_WB;
        end else if (dec.is_branch) begin
          // branches test the latched Z, never the live ALU flags
          case (ir_q[OP_MSB:OP_LSB])
            OP_BEQ:  taken = flag_q[FLAG_Z];
            OP_BNE:  taken = !flag_q[FLAG_Z];
            default: taken = 1'b1;
          endcase
          pc_d    = taken ? ir_q[PW-1:0] : pc_q + PW'(1);
          state_d = S_FETCH;
        end else if (dec.is_in) begin
          state_d = S_WAIT_IN;
        end else if (dec.is_halt) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_q + PW'(1);
          state_d = S_FETCH;
        end
      end
      S_WAIT_IN: begin
        if (bus.in_valid && in_ready_q) begin
          ext_d   = bus.in_data;
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d    = pc_q + PW'(1);
        state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase

    alu_func_d = ((state_d == S_EXEC) || (state_d == S_WB)) ? dec.alu_func : RNOP;
    imm_sel_d  = dec.imm_sel;
    ra1_d      = ir_d[RD_MSB:RD_LSB];
    ra2_d      = ir_d[RS_MSB:RS_LSB];
    wa_d       = ir_d[RD_MSB:RD_LSB];
    imm_d      = n'($signed(ir_d[IMM_MSB:IMM_LSB]));
    reg_we_d   = (state_d == S_WB);
    wd_sel_d   = (state_d == S_WB) && (state_q == S_WAIT_IN);
    in_ready_d = (state_d == S_WAIT_IN);
    halted_d   = (state_d == S_HALT);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      flag_q     <= '0;
      ext_q      <= '0;
      imm_q      <= '0;
      alu_func_q <= RNOP;
      ra1_q      <= '0;
      ra2_q      <= '0;
      wa_q       <= '0;
      imm_sel_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      wd_sel_q   <= 1'b0;
      in_ready_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      flag_q     <= flag_d;
      ext_q      <= ext_d;
      imm_q      <= imm_d;
      alu_func_q <= alu_func_d;
      ra1_q      <= ra1_d;
      ra2_q      <= ra2_d;
      wa_q       <= wa_d;
      imm_sel_q  <= imm_sel_d;
      reg_we_q   <= reg_we_d;
      wd_sel_q   <= wd_sel_d;
      in_ready_q <= in_ready_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.pc_out   = pc_q;
  assign bus.alu_func = alu_func_q;
  assign bus.ra1      = ra1_q;
  assign bus.ra2      = ra2_q;
  assign bus.wa       = wa_q;
  assign bus.imm      = imm_q;
  assign bus.imm_sel  = imm_sel_q;
  assign bus.reg_we   = reg_we_q;
  assign bus.wd_sel   = wd_sel_q;
  assign bus.ext_data = ext_q;
  assign bus.in_ready = in_ready_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_pico_ctrl.sv
// tb_pico_ctrl: directed bench for pico_ctrl with an instruction-level
// reference model checked every cycle, plus literal spot checks.
// Honors PICO_MUL_EN the same way as the design.
module tb_pico_ctrl;
  import pico_pkg::*;

  localparam int unsigned N   = 8;
  localparam int unsigned PWB = 8;
  localparam int unsigned IWB = 16;

  localparam int K_NOP  = 0;
  localparam int K_ALU  = 1;
  localparam int K_BR   = 2;
  localparam int K_IN   = 3;
  localparam int K_HALT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pico_if #(.n(N), .PW(PWB), .IW(IWB)) bus ();

  pico_ctrl #(.n(N), .PW(PWB), .IW(IWB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM
  logic [15:0] rom [0:255];
  logic [15:0] rom_q;
  always @(posedge clk) rom_q <= rom[bus.pc_out];
  assign bus.instr = rom_q;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int kind_of(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: return K_ALU;
`ifdef PICO_MUL_EN
      4'h5, 4'h6: return K_ALU;
`endif
      4'h7, 4'h8, 4'h9: return K_BR;
      4'hA: return K_IN;
      4'hF: return K_HALT;
      default: return K_NOP;
    endcase
  endfunction

  function automatic logic [2:0] func_of(input logic [3:0] op);
    case (op)
      4'h1, 4'h2: return RADD;
      4'h3, 4'h4: return RSUB;
      4'h5, 4'h6: return RMUL;
      default:    return RNOP;
    endcase
  endfunction

  // Reference model: pc, latched flags, input word, halt, cycle within instruction
  logic [7:0] m_pc;
  int         m_c;
  logic [3:0] m_flags;
  logic [7:0] m_ext;
  bit         m_halt;

  always @(posedge clk or posedge reset) begin : model
    logic [15:0] w;
    int k;
    if (reset) begin
      m_pc = 8'h00; m_c = 0; m_flags = 4'h0; m_ext = 8'h00; m_halt = 1'b0;
    end else if (!m_halt) begin
      w = rom[m_pc];
      k = kind_of(w[15:12]);
      case (m_c)
        0, 1: m_c = m_c + 1;
        2: begin
          if (k == K_ALU) begin
            m_flags = bus.flags; m_c = 3;
          end else if (k == K_BR) begin
            if ((w[15:12] == 4'h9) ||
                (w[15:12] == 4'h7 && m_flags[2]) ||
                (w[15:12] == 4'h8 && !m_flags[2])) m_pc = w[7:0];
            else m_pc = m_pc + 8'd1;
            m_c = 0;
          end else if (k == K_IN) begin
            m_c = 3;
          end else if (k == K_HALT) begin
            m_halt = 1'b1;
          end else begin
            m_pc = m_pc + 8'd1; m_c = 0;
          end
        end
        3: begin
          if (k == K_ALU) begin
            m_pc = m_pc + 8'd1; m_c = 0;
          end else if (bus.in_valid) begin
            m_ext = bus.in_data; m_c = 4;
          end
        end
        default: begin
          m_pc = m_pc + 8'd1; m_c = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    logic [15:0] w;
    int k;
    logic [2:0] e_alu;
    bit e_we, e_wd, e_rdy;
    if (!reset) begin
      w     = rom[m_pc];
      k     = kind_of(w[15:12]);
      e_alu = (!m_halt && k == K_ALU && (m_c == 2 || m_c == 3)) ? func_of(w[15:12]) : RNOP;
      e_we  = !m_halt && ((k == K_ALU && m_c == 3) || (k == K_IN && m_c == 4));
      e_wd  = !m_halt && k == K_IN && m_c == 4;
      e_rdy = !m_halt && k == K_IN && m_c == 3;
      check("pc_out",   32'(bus.pc_out),   32'(m_pc));
      check("halted",   32'(bus.halted),   32'(m_halt));
      check("alu_func", 32'(bus.alu_func), 32'(e_alu));
      check("reg_we",   32'(bus.reg_we),   32'(e_we));
      check("wd_sel",   32'(bus.wd_sel),   32'(e_wd));
      check("in_ready", 32'(bus.in_ready), 32'(e_rdy));
      check("ext_data", 32'(bus.ext_data), 32'(m_ext));
      if (e_alu != RNOP) begin
        check("ra1",     32'(bus.ra1),     32'(w[11:10]));
        check("ra2",     32'(bus.ra2),     32'(w[9:8]));
        check("imm",     32'(bus.imm),     32'(w[7:0]));
        check("imm_sel", 32'(bus.imm_sel), 32'(!w[12]));
      end
      if (e_we) check("wa", 32'(bus.wa), 32'(w[11:10]));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic reset_on();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  task automatic reset_off();
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.flags    = 4'h0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset values and ADDI r1,5 followed by HALT
    reset_on();
    rom[0] = 16'h2405;
    @(posedge clk); @(negedge clk); #1;
    check("rst_pc",       32'(bus.pc_out),   32'h0);
    check("rst_alu_func", 32'(bus.alu_func), 32'(RNOP));
    check("rst_reg_we",   32'(bus.reg_we),   32'h0);
    check("rst_wd_sel",   32'(bus.wd_sel),   32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_halted",   32'(bus.halted),   32'h0);
    check("rst_ext_data", 32'(bus.ext_data), 32'h0);
    check("rst_imm",      32'(bus.imm),      32'h0);
    check("rst_imm_sel",  32'(bus.imm_sel),  32'h0);
    reset_off();
    tick(); tick();
    check("addi_func",    32'(bus.alu_func), 32'(RADD));
    check("addi_imm_sel", 32'(bus.imm_sel),  32'h1);
    check("addi_ra1",     32'(bus.ra1),      32'h1);
    check("addi_imm",     32'(bus.imm),      32'h05);
    check("addi_no_we",   32'(bus.reg_we),   32'h0);
    tick();
    check("addi_we",      32'(bus.reg_we),   32'h1);
    check("addi_wa",      32'(bus.wa),       32'h1);
    check("addi_wd_sel",  32'(bus.wd_sel),   32'h0);
    tick();
    check("addi_pc",      32'(bus.pc_out),   32'h1);
    check("addi_we_off",  32'(bus.reg_we),   32'h0);
    repeat (3) tick();
    check("halt_set",     32'(bus.halted),   32'h1);
    for (int i = 0; i < 22; i++) begin
      tick();
      check("halt_pc", 32'(bus.pc_out), 32'h1);
    end
    reset = 1'b1; #1;
    check("halt_rst_halted", 32'(bus.halted), 32'h0);
    check("halt_rst_pc",     32'(bus.pc_out), 32'h0);

    // Reset asserted in the middle of EXEC
    reset_on();
    rom[0] = 16'h0000;
    rom[1] = 16'h2405;
    reset_off();
    repeat (5) tick();
    check("mid_exec_func", 32'(bus.alu_func), 32'(RADD));
    reset = 1'b1; #1;
    check("mid_rst_pc",       32'(bus.pc_out),   32'h0);
    check("mid_rst_func",     32'(bus.alu_func), 32'(RNOP));
    check("mid_rst_reg_we",   32'(bus.reg_we),   32'h0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("mid_rst_halted",   32'(bus.halted),   32'h0);

    // SUB sets Z, BEQ taken, then a branch to its own address
    reset_on();
    rom[0]    = 16'h3500;
    rom[1]    = 16'h7010;
    rom[8'h10] = 16'h7010;
    bus.flags = 4'b0100;
    reset_off();
    repeat (7) tick();
    check("beq_taken_pc", 32'(bus.pc_out), 32'h10);
    repeat (3) tick();
    check("beq_self_pc",  32'(bus.pc_out), 32'h10);

    // Same program with Z clear: BEQ falls through
    reset_on();
    rom[0]    = 16'h3500;
    rom[1]    = 16'h7010;
    bus.flags = 4'b0000;
    reset_off();
    repeat (7) tick();
    check("beq_not_taken_pc", 32'(bus.pc_out), 32'h2);

    // IN r2 with early in_valid ignored, five idle wait cycles, then transfer
    reset_on();
    rom[0] = 16'hA800;
    reset_off();
    tick();
    bus.in_valid = 1'b1; bus.in_data = 8'h33;
    tick(); tick();
    bus.in_valid = 1'b0;
    check("in_early_ignored", 32'(bus.ext_data), 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("in_wait_ready", 32'(bus.in_ready), 32'h1);
      check("in_wait_no_we", 32'(bus.reg_we),   32'h0);
      tick();
    end
    bus.in_valid = 1'b1; bus.in_data = 8'h7F;
    tick();
    bus.in_valid = 1'b0;
    check("in_ext_data", 32'(bus.ext_data), 32'h7F);
    check("in_we",       32'(bus.reg_we),   32'h1);
    check("in_wa",       32'(bus.wa),       32'h2);
    check("in_wd_sel",   32'(bus.wd_sel),   32'h1);
    check("in_ready_lo", 32'(bus.in_ready), 32'h0);
    tick();
    check("in_pc",       32'(bus.pc_out),   32'h1);

    // Reset asserted while waiting for input drops in_ready at once
    reset_on();
    rom[0] = 16'hA800;
    reset_off();
    repeat (3) tick();
    check("wait_ready", 32'(bus.in_ready), 32'h1);
    reset = 1'b1; #1;
    check("wait_rst_ready", 32'(bus.in_ready), 32'h0);

    // MUL r1,r2 with Z live, then BEQ 5
    reset_on();
    rom[0]    = 16'h5600;
    rom[1]    = 16'h7005;
    bus.flags = 4'b0100;
    reset_off();
    tick(); tick();
`ifdef PICO_MUL_EN
    check("mul_func", 32'(bus.alu_func), 32'(RMUL));
    tick();
    check("mul_we",   32'(bus.reg_we),   32'h1);
    tick();
    check("mul_pc",   32'(bus.pc_out),   32'h1);
    bus.flags = 4'b0000;
    repeat (3) tick();
    check("mul_beq_pc", 32'(bus.pc_out), 32'h5);
`else
    check("mul_off_func", 32'(bus.alu_func), 32'(RNOP));
    tick();
    check("mul_off_no_we", 32'(bus.reg_we), 32'h0);
    check("mul_off_pc",    32'(bus.pc_out), 32'h1);
    repeat (3) tick();
    check("mul_off_beq_pc", 32'(bus.pc_out), 32'h2);
`endif

    // BNE taken, illegal opcode, jumps and pc wrap from 0xFF
    reset_on();
    rom[0]     = 16'h8007;
    rom[7]     = 16'hB123;
    rom[8]     = 16'h9010;
    rom[8'h10] = 16'h90FF;
    rom[8'hFF] = 16'h0000;
    bus.flags  = 4'b0100;
    reset_off();
    repeat (3) tick();
    check("bne_pc",     32'(bus.pc_out), 32'h07);
    repeat (3) tick();
    check("illegal_pc", 32'(bus.pc_out), 32'h08);
    repeat (3) tick();
    check("j10_pc",     32'(bus.pc_out), 32'h10);
    repeat (3) tick();
    check("jff_pc",     32'(bus.pc_out), 32'hFF);
    repeat (3) tick();
    check("wrap_pc",    32'(bus.pc_out), 32'h00);

    reset = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
